// File: rtl/fft_bfly_r2.sv
// Radix-2 DIT butterfly: y0 = a + w*b, y1 = a - w*b, twiddle read from an external 1-cycle cos/sin ROM.
// Optional macro BFLY_SCALE_EN: halve each output (round-half-up) instead of saturating.
module fft_bfly_r2 #(
  parameter int W     = 32'd16,
  parameter int TW_W  = 32'd16,
  parameter int LOG2N = 32'd7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [W-1:0]    ar,
  input  logic signed [W-1:0]    ai,
  input  logic signed [W-1:0]    br,
  input  logic signed [W-1:0]    bi,
  input  logic [LOG2N-2:0]       k,
  input  logic                   inv,
  output logic [LOG2N-2:0]       tw_addr,
  input  logic signed [TW_W-1:0] tw_cos,
  input  logic signed [TW_W-1:0] tw_sin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [W-1:0]    y0r,
  output logic signed [W-1:0]    y0i,
  output logic signed [W-1:0]    y1r,
  output logic signed [W-1:0]    y1i,
  output logic                   ovf
);

  localparam int PW  = W + TW_W + 1;  // product of W-bit data and (TW_W+1)-bit twiddle
  localparam int SW  = PW + 1;        // sum/difference of two products
  localparam int TRW = W + 2;         // rotated term after rescale
  localparam int AW  = W + 3;         // butterfly sum before reduction

  localparam logic signed [SW-1:0] RND =
    {{(SW-TW_W+1){1'b0}}, 1'b1, {(TW_W-2){1'b0}}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TWAIT = 3'd1,
    MUL1  = 3'd2,
    MUL2  = 3'd3,
    SUM   = 3'd4,
    ADD   = 3'd5,
    HOLD  = 3'd6
  } state_t;

  state_t state_r, state_s;

  logic                   in_ready_r, out_valid_r, ovf_r, inv_r, accept_s;
  logic [LOG2N-2:0]       tw_addr_r;
  logic signed [W-1:0]    ar_r, ai_r, br_r, bi_r;
  logic signed [TW_W:0]   wr_r, wi_r, wr_s, wi_s;
  logic signed [PW-1:0]   p1_r, p2_r, p3_r, p4_r;
  logic signed [TRW-1:0]  tr_r, ti_r, tr_s, ti_s;
  logic signed [AW-1:0]   s0r_s, s0i_s, s1r_s, s1i_s;
  logic signed [W-1:0]    y0r_r, y0i_r, y1r_r, y1i_r;
  logic signed [W-1:0]    y0r_s, y0i_s, y1r_s, y1i_s;
  logic                   clip_s;

  function automatic logic signed [PW-1:0] cmul(input logic signed [W-1:0]  x,
                                                input logic signed [TW_W:0] c);
    cmul = PW'(x) * PW'(c);
  endfunction

`ifdef BFLY_SCALE_EN
  localparam logic signed [AW-1:0] ONE_A = {{(AW-1){1'b0}}, 1'b1};

  function automatic logic signed [W-1:0] reduce_w(input logic signed [AW-1:0] s);
    reduce_w = W'((s + ONE_A) >>> 1);
  endfunction
`else
  localparam logic signed [AW-1:0] SMAX = {4'b0000, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = {4'b1111, {(W-1){1'b0}}};

  function automatic logic signed [W-1:0] reduce_w(input logic signed [AW-1:0] s);
    if (s > SMAX) begin
      reduce_w = W'(SMAX);
    end else if (s < SMIN) begin
      reduce_w = W'(SMIN);
    end else begin
      reduce_w = W'(s);
    end
  endfunction

  function automatic logic clip_w(input logic signed [AW-1:0] s);
    clip_w = (s > SMAX) || (s < SMIN);
  endfunction
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and accept strobe
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          accept_s = 1'b1;
          state_s  = TWAIT;
        end else begin
          state_s  = IDLE;
        end
      end
      TWAIT: state_s = MUL1;
      MUL1:  state_s = MUL2;
      MUL2:  state_s = SUM;
      SUM:   state_s = ADD;
      ADD:   state_s = HOLD;
      HOLD: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Twiddle as seen by the multipliers; inverse mode conjugates (sign flip of the sine term)
  always_comb begin
    wr_s = (TW_W+1)'(tw_cos);
    if (inv_r) begin
      wi_s = (TW_W+1)'(tw_sin);
    end else begin
      wi_s = -((TW_W+1)'(tw_sin));
    end
  end

  // Rescale of the rotated term and the butterfly sums
  always_comb begin
    tr_s  = TRW'((SW'(p1_r) - SW'(p2_r) + RND) >>> (TW_W-1));
    ti_s  = TRW'((SW'(p3_r) + SW'(p4_r) + RND) >>> (TW_W-1));
    s0r_s = AW'(ar_r) + AW'(tr_r);
    s0i_s = AW'(ai_r) + AW'(ti_r);
    s1r_s = AW'(ar_r) - AW'(tr_r);
    s1i_s = AW'(ai_r) - AW'(ti_r);
  end

  // Output reduction to W bits
  always_comb begin
    y0r_s  = reduce_w(s0r_s);
    y0i_s  = reduce_w(s0i_s);
    y1r_s  = reduce_w(s1r_s);
    y1i_s  = reduce_w(s1i_s);
`ifdef BFLY_SCALE_EN
    clip_s = 1'b0;
`else
    clip_s = clip_w(s0r_s) | clip_w(s0i_s) | clip_w(s1r_s) | clip_w(s1i_s);
`endif
  end

  // Handshake flags and ROM address
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      tw_addr_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            in_ready_r <= 1'b0;
            tw_addr_r  <= k;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        ADD: out_valid_r <= 1'b1;
        HOLD: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          in_ready_r <= 1'b0;
        end
      endcase
    end
  end

  // Datapath pipeline: operands, products, rotated term, results, sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      ar_r  <= '0;
      ai_r  <= '0;
      br_r  <= '0;
      bi_r  <= '0;
      inv_r <= 1'b0;
      wr_r  <= '0;
      wi_r  <= '0;
      p1_r  <= '0;
      p2_r  <= '0;
      p3_r  <= '0;
      p4_r  <= '0;
      tr_r  <= '0;
      ti_r  <= '0;
      y0r_r <= '0;
      y0i_r <= '0;
      y1r_r <= '0;
      y1i_r <= '0;
      ovf_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            ar_r  <= ar;
            ai_r  <= ai;
            br_r  <= br;
            bi_r  <= bi;
            inv_r <= inv;
          end
        end
        MUL1: begin
          wr_r <= wr_s;
          wi_r <= wi_s;
          p1_r <= cmul(br_r, wr_s);
          p2_r <= cmul(bi_r, wi_s);
        end
        MUL2: begin
          p3_r <= cmul(br_r, wi_r);
          p4_r <= cmul(bi_r, wr_r);
        end
        SUM: begin
          tr_r <= tr_s;
          ti_r <= ti_s;
        end
        ADD: begin
          y0r_r <= y0r_s;
          y0i_r <= y0i_s;
          y1r_r <= y1r_s;
          y1i_r <= y1i_s;
          ovf_r <= ovf_r | clip_s;
        end
        default: begin
          ovf_r <= ovf_r;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign tw_addr   = tw_addr_r;
  assign y0r       = y0r_r;
  assign y0i       = y0i_r;
  assign y1r       = y1r_r;
  assign y1i       = y1i_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_fft_bfly_r2.sv
// Directed-vector bench for fft_bfly_r2 (W=16, TW_W=16, LOG2N=7) with a 1-cycle twiddle ROM model.
module tb_fft_bfly_r2;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, inv, out_valid, out_ready, ovf;
  logic signed [15:0] ar, ai, br, bi, tw_cos, tw_sin, y0r, y0i, y1r, y1i;
  logic [5:0] k, tw_addr;

  logic signed [15:0] rom_cos [64];
  logic signed [15:0] rom_sin [64];

  int errors = 0;
  int checks = 0;
  bit ovf_exp;

  typedef struct {
    logic signed [15:0] ar, ai, br, bi;
    logic [5:0]         k;
    logic               inv;
    logic signed [15:0] c, s;
    int                 s0r, s0i, s1r, s1i;  // unreduced a +/- w*b
  } vec_t;

  fft_bfly_r2 #(.W(16), .TW_W(16), .LOG2N(7)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ar(ar), .ai(ai), .br(br), .bi(bi), .k(k), .inv(inv),
    .tw_addr(tw_addr), .tw_cos(tw_cos), .tw_sin(tw_sin),
    .out_valid(out_valid), .out_ready(out_ready),
    .y0r(y0r), .y0i(y0i), .y1r(y1r), .y1i(y1i), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tw_cos <= rom_cos[tw_addr];
    tw_sin <= rom_sin[tw_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  function automatic int exp_y(input int s);
    int h;
    logic signed [15:0] t16;
`ifdef BFLY_SCALE_EN
    h = (s + 1) >>> 1;
    t16 = h[15:0];
    return int'(t16);
`else
    h = s;
    if (h > 32767) h = 32767;
    else if (h < -32768) h = -32768;
    t16 = h[15:0];
    return int'(t16);
`endif
  endfunction

  function automatic bit exp_clip(input int s);
`ifdef BFLY_SCALE_EN
    return (s != s);
`else
    return (s > 32767) || (s < -32768);
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("ready_valid_exclusive", int'(in_ready & out_valid), 0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_tw_addr"}, int'(tw_addr), 0);
    chk({tag, "_y0r"}, y0r, 0);
    chk({tag, "_y0i"}, y0i, 0);
    chk({tag, "_y1r"}, y1r, 0);
    chk({tag, "_y1i"}, y1i, 0);
    chk({tag, "_ovf"}, int'(ovf), 0);
  endtask

  // Offer v, return #1 after the accept edge with inputs scrambled
  task automatic offer(input vec_t v, input string tag);
    int n;
    @(negedge clk);
    rom_cos[v.k] = v.c;
    rom_sin[v.k] = v.s;
    ar = v.ar; ai = v.ai; br = v.br; bi = v.bi; k = v.k; inv = v.inv;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ar = ~ar; ai = ~ai; br = ~br; bi = ~bi; k = ~k; inv = ~inv;
    chk({tag, "_tw_addr"}, int'(tw_addr), int'(v.k));
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!out_valid && lat < 20);
  endtask

  task automatic check_out(input vec_t v, input string tag);
    ovf_exp = ovf_exp | exp_clip(v.s0r) | exp_clip(v.s0i) | exp_clip(v.s1r) | exp_clip(v.s1i);
    chk({tag, "_out_valid"}, int'(out_valid), 1);
    chk({tag, "_y0r"}, y0r, exp_y(v.s0r));
    chk({tag, "_y0i"}, y0i, exp_y(v.s0i));
    chk({tag, "_y1r"}, y1r, exp_y(v.s1r));
    chk({tag, "_y1i"}, y1i, exp_y(v.s1i));
    chk({tag, "_ovf"}, int'(ovf), int'(ovf_exp));
  endtask

  task automatic run(input vec_t v, input string tag);
    int lat;
    offer(v, tag);
    wait_out(lat);
    chk({tag, "_latency"}, lat, 5);
    check_out(v, tag);
    tick();
    chk({tag, "_release_out_valid"}, int'(out_valid), 0);
    chk({tag, "_release_in_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    vec_t vt [7];
    int   lat;
    int   seen;

    vt[0] = '{16'sd1000, -16'sd2000, 16'sd300, 16'sd400, 6'd0, 1'b0, 16'sd32767, 16'sd0,
              32'sd1300, -32'sd1600, 32'sd700, -32'sd2400};
    vt[1] = '{16'sd0, 16'sd0, 16'sd100, 16'sd200, 6'd5, 1'b0, 16'sd0, 16'sd32767,
              32'sd200, -32'sd100, -32'sd200, 32'sd100};
    vt[2] = '{16'sd0, 16'sd0, 16'sd100, 16'sd200, 6'd5, 1'b1, 16'sd0, 16'sd32767,
              -32'sd200, 32'sd100, 32'sd200, -32'sd100};
    vt[3] = '{16'sd10, -16'sd10, 16'sd1, -16'sd1, 6'd17, 1'b0, 16'sd16384, 16'sd0,
              32'sd11, -32'sd10, 32'sd9, -32'sd10};
    vt[4] = '{16'sd0, 16'sd0, 16'sd100, -16'sd50, 6'd33, 1'b0, 16'sh8000, 16'sh8000,
              -32'sd50, 32'sd150, 32'sd50, -32'sd150};
    vt[5] = '{16'sd32000, 16'sd0, 16'sd32000, 16'sd0, 6'd63, 1'b0, 16'sd32767, 16'sd0,
              32'sd63999, 32'sd0, 32'sd1, 32'sd0};
    vt[6] = '{16'sh8000, 16'sh8000, 16'sh8000, 16'sd32767, 6'd2, 1'b0, 16'sd32767, 16'sd0,
              -32'sd65535, -32'sd2, -32'sd1, -32'sd65534};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; inv = 1'b0; k = 6'd0;
    ar = 16'sd0; ai = 16'sd0; br = 16'sd0; bi = 16'sd0;
    ovf_exp = 1'b0;
    for (int i = 0; i < 64; i++) begin
      rom_cos[i] = 16'sd0;
      rom_sin[i] = 16'sd0;
    end

    repeat (3) @(posedge clk);
    #1;
    reset_checks("reset");
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("ready_after_reset", int'(in_ready), 1);

    for (int i = 0; i < 7; i++) begin
      run(vt[i], $sformatf("vec%0d", i));
    end

    // Backpressure: results and flags must hold while out_ready is low
    out_ready = 1'b0;
    offer(vt[3], "bp");
    wait_out(lat);
    chk("bp_latency", lat, 5);
    check_out(vt[3], "bp");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_out_valid", int'(out_valid), 1);
      chk("bp_hold_in_ready", int'(in_ready), 0);
      chk("bp_hold_y0r", y0r, exp_y(vt[3].s0r));
      chk("bp_hold_y1r", y1r, exp_y(vt[3].s1r));
    end
    @(negedge clk);
    out_ready = 1'b1;
    tick();
    chk("bp_release_out_valid", int'(out_valid), 0);
    chk("bp_release_in_ready", int'(in_ready), 1);

    // Reset while the transaction sits in MUL2
    offer(vt[1], "abort");
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    reset_checks("abort_reset");
    ovf_exp = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("abort_ready_after_reset", int'(in_ready), 1);
    seen = 0;
    repeat (12) begin
      tick();
      if (out_valid) seen = 1;
    end
    chk("abort_no_out_valid", seen, 0);
    run(vt[0], "post_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
